// File: rtl/dlfloat_result_tx_if.sv
// Handshake bundle for the DLFloat16 result serializer: result word in, byte stream out, plus status.
// DEPTH must match the DEPTH of the attached dlfloat_result_tx so that level widths agree.
interface dlfloat_result_tx_if #(parameter int DEPTH = 4);
  logic                     res_valid;
  logic [15:0]              res_data;
  logic                     res_ready;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_last;
  logic                     tx_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic                     clr_ovf;

  modport master (
    output res_valid, res_data, tx_ready, clr_ovf,
    input  res_ready, tx_data, tx_valid, tx_last, level, overflow
  );

  modport slave (
    input  res_valid, res_data, tx_ready, clr_ovf,
    output res_ready, tx_data, tx_valid, tx_last, level, overflow
  );
endinterface

// File: rtl/dlfloat_result_tx.sv
// Buffers 16-bit DLFloat16 MAC results in a small FIFO and streams each one out
// as two bytes (low byte first) on a registered valid/ready byte port.
module dlfloat_result_tx #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dlfloat_result_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  // DEPTH is a power of two, so "full" is just the top bit of the occupancy count
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_q;
  logic          ovf_q;
  logic          full, push, drop, pop, have_word;
  logic [15:0]   head, word_q, word_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;

  assign full      = (level_q == FULL_LVL);
  assign have_word = (level_q != '0);
  assign push      = bus.res_valid && !full;
  assign drop      = bus.res_valid && full;
  assign head      = mem[rd_ptr];

  assign bus.res_ready = !full;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_last   = tx_last_q;
  assign bus.level     = level_q;
  assign bus.overflow  = ovf_q;

  // Storage has no reset; occupancy tracking guarantees stale entries are never popped.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.res_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // A drop wins over a same-cycle clear so no lost word goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (bus.clr_ovf) ovf_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        if (have_word) begin
          pop        = 1'b1;
          word_d     = head;
          tx_data_d  = head[7:0];
          tx_valid_d = 1'b1;
          state_d    = LO;
        end
      end
      LO: begin
        if (bus.tx_ready) begin
          tx_data_d = word_q[15:8];
          tx_last_d = 1'b1;
          state_d   = HI;
        end
      end
      HI: begin
        if (bus.tx_ready) begin
          // Chain straight into the next word so a busy FIFO streams without a gap
          if (have_word) begin
            pop       = 1'b1;
            word_d    = head;
            tx_data_d = head[7:0];
            tx_last_d = 1'b0;
            state_d   = LO;
          end else begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end
endmodule
